// File: rtl/blk_xfer_seq.sv
// Block-transfer sequencer for the TII/TDD/TIN/TIA/TAI instructions: one READ/WRITE strobe pair per byte.
// Optional abort input enabled by defining BLKXFER_ABORT_EN.
module blk_xfer_seq #(
    parameter int SETUP_CYCLES = 17,
    parameter int BYTE_GAP     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RDY,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    input  logic [7:0]  rd_data,
`ifdef BLKXFER_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] vaddr,
    output logic        rd,
    output logic        we,
    output logic [7:0]  wr_data
);

    localparam logic [2:0] M_TII = 3'd0;
    localparam logic [2:0] M_TDD = 3'd1;
    localparam logic [2:0] M_TIN = 3'd2;
    localparam logic [2:0] M_TIA = 3'd3;
    localparam logic [2:0] M_TAI = 3'd4;

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES);
    localparam logic [7:0] GAP_LD   = 8'(BYTE_GAP);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t      state_r;
    logic [15:0] src_cur_r;
    logic [15:0] dst_cur_r;
    logic [16:0] remaining_r;
    logic [2:0]  mode_r;
    logic        alt_r;
    logic [7:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] vaddr_r;
    logic        rd_r;
    logic        we_r;
    logic [7:0]  wr_data_r;

    logic [15:0] src_nxt_s;
    logic [15:0] dst_nxt_s;
    logic        alt_nxt_s;
    logic [16:0] rem_nxt_s;
    logic [2:0]  mode_dec_s;
    logic        abort_s;

`ifdef BLKXFER_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // TAI reads from base+alt, TIA writes to base+alt; every other mode uses the pointer directly.
    function automatic logic [15:0] src_eff(input logic [2:0] m, input logic [15:0] base, input logic a);
        src_eff = (m == M_TAI) ? (base + {15'd0, a}) : base;
    endfunction

    function automatic logic [15:0] dst_eff(input logic [2:0] m, input logic [15:0] base, input logic a);
        dst_eff = (m == M_TIA) ? (base + {15'd0, a}) : base;
    endfunction

    assign mode_dec_s = (mode > M_TAI) ? M_TII : mode;

    // Pointer, alternation and byte-count values that take effect when a WRITE closes.
    always_comb begin
        src_nxt_s = src_cur_r;
        dst_nxt_s = dst_cur_r;
        alt_nxt_s = alt_r;
        rem_nxt_s = remaining_r - 17'd1;
        case (mode_r)
            M_TII: begin
                src_nxt_s = src_cur_r + 16'd1;
                dst_nxt_s = dst_cur_r + 16'd1;
            end
            M_TDD: begin
                src_nxt_s = src_cur_r - 16'd1;
                dst_nxt_s = dst_cur_r - 16'd1;
            end
            M_TIN: begin
                src_nxt_s = src_cur_r + 16'd1;
            end
            M_TIA: begin
                src_nxt_s = src_cur_r + 16'd1;
                alt_nxt_s = ~alt_r;
            end
            M_TAI: begin
                dst_nxt_s = dst_cur_r + 16'd1;
                alt_nxt_s = ~alt_r;
            end
            default: begin
                src_nxt_s = src_cur_r + 16'd1;
                dst_nxt_s = dst_cur_r + 16'd1;
            end
        endcase
    end

    // Sequencer FSM; strobes and vaddr are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            src_cur_r   <= 16'd0;
            dst_cur_r   <= 16'd0;
            remaining_r <= 17'd0;
            mode_r      <= 3'd0;
            alt_r       <= 1'b0;
            cnt_r       <= 8'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            vaddr_r     <= 16'd0;
            rd_r        <= 1'b0;
            we_r        <= 1'b0;
            wr_data_r   <= 8'd0;
        end else if (RDY) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        src_cur_r   <= src;
                        dst_cur_r   <= dst;
                        remaining_r <= (len == 16'd0) ? 17'h10000 : {1'b0, len};
                        mode_r      <= mode_dec_s;
                        alt_r       <= 1'b0;
                        busy_r      <= 1'b1;
                        if (SETUP_CYCLES == 0) begin
                            state_r <= ST_READ;
                            rd_r    <= 1'b1;
                            vaddr_r <= src;
                        end else begin
                            state_r <= ST_SETUP;
                            cnt_r   <= SETUP_LD;
                        end
                    end
                end
                ST_SETUP: begin
                    if (abort_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (cnt_r <= 8'd1) begin
                        state_r <= ST_READ;
                        rd_r    <= 1'b1;
                        vaddr_r <= src_eff(mode_r, src_cur_r, alt_r);
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_READ: begin
                    rd_r      <= 1'b0;
                    wr_data_r <= rd_data;
                    if (abort_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_WRITE;
                        we_r    <= 1'b1;
                        vaddr_r <= dst_eff(mode_r, dst_cur_r, alt_r);
                    end
                end
                ST_WRITE: begin
                    we_r        <= 1'b0;
                    src_cur_r   <= src_nxt_s;
                    dst_cur_r   <= dst_nxt_s;
                    alt_r       <= alt_nxt_s;
                    remaining_r <= rem_nxt_s;
                    if (abort_s || (rem_nxt_s == 17'd0 && BYTE_GAP == 0)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (BYTE_GAP > 0) begin
                        state_r <= ST_GAP;
                        cnt_r   <= GAP_LD;
                    end else begin
                        state_r <= ST_READ;
                        rd_r    <= 1'b1;
                        vaddr_r <= src_eff(mode_r, src_nxt_s, alt_nxt_s);
                    end
                end
                ST_GAP: begin
                    if (abort_s || (cnt_r <= 8'd1 && remaining_r == 17'd0)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (cnt_r <= 8'd1) begin
                        state_r <= ST_READ;
                        rd_r    <= 1'b1;
                        vaddr_r <= src_eff(mode_r, src_cur_r, alt_r);
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    rd_r    <= 1'b0;
                    we_r    <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign vaddr   = vaddr_r;
    assign rd      = rd_r;
    assign we      = we_r;
    assign wr_data = wr_data_r;

endmodule
